alarm_time_ctrl: RTL and testbench

//  Mode/sequencing controller for the alarm clock. Owns the HH:MM:SS time and the HH:MM alarm.

---
 rtl/alarm_time_ctrl_pkg.sv | 38 +++
 rtl/alarm_time_ctrl_bcd_mod_counter.sv | 44 ++++
 rtl/alarm_time_ctrl.sv | 168 ++++++++++++++++
 tb/tb_alarm_time_ctrl.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/alarm_time_ctrl_pkg.sv
// Shared definitions for the alarm clock controller: mode encodings,
// BCD counter limits, display field offsets and BCD/binary helpers.
package alarm_time_ctrl_pkg;

    typedef enum logic [2:0] {
        MODE_RUN    = 3'd0,
        MODE_SET_TH = 3'd1,
        MODE_SET_TM = 3'd2,
        MODE_SET_AH = 3'd3,
        MODE_SET_AM = 3'd4
    } mode_e;

    localparam logic [7:0] MIN_MAX_BCD  = 8'h59;
    localparam logic [7:0] HOUR_MAX_BCD = 8'h23;

    // Bit offsets of the HH and MM fields inside disp_bcd.
    localparam int DISP_HOUR_LSB = 8;
    localparam int DISP_MIN_LSB  = 0;

    function automatic mode_e next_mode(input mode_e m);
        case (m)
            MODE_RUN:    return MODE_SET_TH;
            MODE_SET_TH: return MODE_SET_TM;
            MODE_SET_TM: return MODE_SET_AH;
            MODE_SET_AH: return MODE_SET_AM;
            default:     return MODE_RUN;
        endcase
    endfunction

    function automatic logic [6:0] bcd_to_bin(input logic [7:0] b);
        return 7'(b[7:4]) * 7'd10 + 7'(b[3:0]);
    endfunction

    function automatic logic [7:0] bin_to_bcd(input logic [6:0] v);
        return {4'(v / 7'd10), 4'(v % 7'd10)};
    endfunction

endpackage

// File: rtl/alarm_time_ctrl_bcd_mod_counter.sv
// Two-digit BCD counter wrapping at MAX_BCD back to 00, with synchronous
// clear (priority over inc), a look-ahead next value and a wrap carry.
module alarm_time_ctrl_bcd_mod_counter #(
    parameter logic [7:0] MAX_BCD = 8'h59
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       inc_i,
    input  logic       clr_i,
    output logic [7:0] val_o,
    output logic [7:0] nxt_o,
    output logic       carry_o
);

    logic [7:0] cnt_q, cnt_d;

    // Next count: clear, wrap at the limit, or BCD ones/tens step.
    always_comb begin
        // NOTE: default first so every path assigns cnt_d and no latch is inferred.
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            if (cnt_q == MAX_BCD)
                cnt_d = '0;
            else if (cnt_q[3:0] == 4'd9)
                cnt_d = {cnt_q[7:4] + 4'd1, 4'd0};
            else
                cnt_d = {cnt_q[7:4], cnt_q[3:0] + 4'd1};
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: non-blocking assignment keeps every register updating from pre-edge values.
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign val_o   = cnt_q;
    assign nxt_o   = cnt_d;
    assign carry_o = inc_i & ~clr_i & (cnt_q == MAX_BCD);

endmodule

// File: rtl/alarm_time_ctrl.sv
// Alarm clock mode/sequencing controller: timekeeping, set-time/set-alarm
// mode FSM, alarm trigger, ring length, snooze and dismiss.
module alarm_time_ctrl
    import alarm_time_ctrl_pkg::*;
#(
    parameter int SNOOZE_MIN = 5,
    parameter int RING_SEC   = 60
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick_1hz,
    input  logic        btn_mode,
    input  logic        btn_inc,
    input  logic        btn_snooze,
    input  logic        alarm_en,
    output logic [15:0] disp_bcd,
    output logic [7:0]  sec_bcd,
    output logic [2:0]  mode,
    output logic        ringing,
    output logic        blink
);

    mode_e       state_q, state_d;
    logic        ringing_q, ringing_d;
    logic        blink_q, blink_d;
    logic        snz_armed_q, snz_armed_d;
    logic [15:0] snz_hm_q, snz_hm_d;
    logic [7:0]  ring_cnt_q, ring_cnt_d;
    logic [15:0] disp_q, disp_d;

    logic [7:0] sec_val, sec_nxt, min_val, min_nxt, hour_val, hour_nxt;
    logic [7:0] amin_val, amin_nxt, ahour_val, ahour_nxt;
    logic       sec_carry, min_carry, hour_carry, amin_carry, ahour_carry;

    // Wrap-around HH:MM plus the snooze interval, in BCD.
    function automatic logic [15:0] add_snooze(input logic [15:0] hm);
        logic [6:0] mb, hb;
        mb = bcd_to_bin(hm[DISP_MIN_LSB +: 8]) + 7'(SNOOZE_MIN);
        hb = bcd_to_bin(hm[DISP_HOUR_LSB +: 8]);
        if (mb >= 7'd60) begin
            mb = mb - 7'd60;
            hb = (hb == 7'd23) ? 7'd0 : hb + 7'd1;
        end
        return {bin_to_bcd(hb), bin_to_bcd(mb)};
    endfunction

    // Seconds run in RUN and SET_A*; ringing blocks mode changes so the pulse only dismisses.
    wire time_runs  = (state_q != MODE_SET_TH) && (state_q != MODE_SET_TM);
    wire tick_run   = tick_1hz && time_runs;
    wire mode_adv   = btn_mode && !ringing_q;
    wire inc_eff    = btn_inc && !btn_mode;
    wire inc_th     = inc_eff && (state_q == MODE_SET_TH);
    wire inc_tm     = inc_eff && (state_q == MODE_SET_TM);
    wire inc_ah     = inc_eff && (state_q == MODE_SET_AH);
    wire inc_am     = inc_eff && (state_q == MODE_SET_AM);
    wire enter_set  = mode_adv && (state_q == MODE_RUN);

    alarm_time_ctrl_bcd_mod_counter #(.MAX_BCD(MIN_MAX_BCD)) u_sec (
        .clk(clk), .reset(reset), .inc_i(tick_run), .clr_i(enter_set),
        .val_o(sec_val), .nxt_o(sec_nxt), .carry_o(sec_carry));

    alarm_time_ctrl_bcd_mod_counter #(.MAX_BCD(MIN_MAX_BCD)) u_min (
        .clk(clk), .reset(reset), .inc_i(sec_carry || inc_tm), .clr_i(1'b0),
        .val_o(min_val), .nxt_o(min_nxt), .carry_o(min_carry));

    // Editing minutes must not roll the hour, so only tick-driven wraps carry.
    alarm_time_ctrl_bcd_mod_counter #(.MAX_BCD(HOUR_MAX_BCD)) u_hour (
        .clk(clk), .reset(reset), .inc_i((min_carry && !inc_tm) || inc_th), .clr_i(1'b0),
        .val_o(hour_val), .nxt_o(hour_nxt), .carry_o(hour_carry));

    alarm_time_ctrl_bcd_mod_counter #(.MAX_BCD(MIN_MAX_BCD)) u_amin (
        .clk(clk), .reset(reset), .inc_i(inc_am), .clr_i(1'b0),
        .val_o(amin_val), .nxt_o(amin_nxt), .carry_o(amin_carry));

    alarm_time_ctrl_bcd_mod_counter #(.MAX_BCD(HOUR_MAX_BCD)) u_ahour (
        .clk(clk), .reset(reset), .inc_i(inc_ah), .clr_i(1'b0),
        .val_o(ahour_val), .nxt_o(ahour_nxt), .carry_o(ahour_carry));

    logic unused_sigs;
    assign unused_sigs = ^{hour_carry, amin_carry, ahour_carry, sec_nxt, min_val, hour_val};

    // An armed snooze replaces the alarm as the compare target.
    wire [15:0] tgt_hm  = snz_armed_q ? snz_hm_q : {ahour_val, amin_val};
    wire        trigger = alarm_en && sec_carry && ({hour_nxt, min_nxt} == tgt_hm);

    // Mode FSM next state and blink.
    always_comb begin
        state_d = state_q;
        blink_d = blink_q;
        if (mode_adv)
            state_d = next_mode(state_q);
        if (state_d == MODE_RUN)
            blink_d = 1'b0;
        else if (tick_1hz && state_q != MODE_RUN)
            blink_d = ~blink_q;
    end

    // Ring, snooze and auto-silence control; alarm_en low overrides everything.
    always_comb begin
        ringing_d   = ringing_q;
        ring_cnt_d  = ring_cnt_q;
        snz_armed_d = snz_armed_q;
        snz_hm_d    = snz_hm_q;
        if (!alarm_en) begin
            ringing_d   = 1'b0;
            snz_armed_d = 1'b0;
        end else if (trigger) begin
            ringing_d   = 1'b1;
            ring_cnt_d  = '0;
            snz_armed_d = 1'b0;
            snz_hm_d    = add_snooze(tgt_hm);
        end else begin
            if (ringing_q) begin
                if (btn_snooze) begin
                    ringing_d   = 1'b0;
                    snz_armed_d = 1'b1;
                end else if (btn_mode) begin
                    ringing_d   = 1'b0;
                    snz_armed_d = 1'b0;
                end else if (tick_1hz) begin
                    if (ring_cnt_q + 8'd1 == 8'(RING_SEC)) begin
                        ringing_d   = 1'b0;
                        snz_armed_d = 1'b0;
                    end else begin
                        ring_cnt_d = ring_cnt_q + 8'd1;
                    end
                end
            end
            if (inc_ah || inc_am)
                snz_armed_d = 1'b0;
        end
    end

    // Display shows the alarm while it is being edited, otherwise the time.
    always_comb begin
        disp_d = {hour_nxt, min_nxt};
        if (state_d == MODE_SET_AH || state_d == MODE_SET_AM)
            disp_d = {ahour_nxt, amin_nxt};
    end

    // Controller state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= MODE_RUN;
            blink_q     <= 1'b0;
            ringing_q   <= 1'b0;
            ring_cnt_q  <= '0;
            snz_armed_q <= 1'b0;
            snz_hm_q    <= '0;
            disp_q      <= '0;
        end else begin
            state_q     <= state_d;
            blink_q     <= blink_d;
            ringing_q   <= ringing_d;
            ring_cnt_q  <= ring_cnt_d;
            snz_armed_q <= snz_armed_d;
            snz_hm_q    <= snz_hm_d;
            disp_q      <= disp_d;
        end
    end

    assign disp_bcd = disp_q;
    assign sec_bcd  = sec_val;
    assign mode     = state_q;
    assign ringing  = ringing_q;
    assign blink    = blink_q;

endmodule

// File: tb/tb_alarm_time_ctrl.sv
// Directed self-checking bench for alarm_time_ctrl.
module tb_alarm_time_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        tick_1hz = 1'b0;
    logic        btn_mode = 1'b0;
    logic        btn_inc = 1'b0;
    logic        btn_snooze = 1'b0;
    logic        alarm_en = 1'b0;
    logic [15:0] disp_bcd;
    logic [7:0]  sec_bcd;
    logic [2:0]  mode;
    logic        ringing;
    logic        blink;

    int total = 0;
    int bad   = 0;

    alarm_time_ctrl #(.SNOOZE_MIN(5), .RING_SEC(60)) dut (
        .clk(clk), .reset(reset), .tick_1hz(tick_1hz), .btn_mode(btn_mode),
        .btn_inc(btn_inc), .btn_snooze(btn_snooze), .alarm_en(alarm_en),
        .disp_bcd(disp_bcd), .sec_bcd(sec_bcd), .mode(mode),
        .ringing(ringing), .blink(blink));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One clock with the given pulses; outputs are stable 1 ns after the edge.
    task automatic cyc(input logic t, input logic m, input logic i, input logic s);
        @(negedge clk);
        tick_1hz = t; btn_mode = m; btn_inc = i; btn_snooze = s;
        @(posedge clk);
        #1;
        tick_1hz = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0; btn_snooze = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic presses(input int n, input logic m, input logic i);
        for (int k = 0; k < n; k++) cyc(1'b0, m, i, 1'b0);
    endtask

    task automatic do_reset(input logic en);
        @(negedge clk);
        reset = 1'b1;
        alarm_en = en;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Reset, enable, program alarm 00:02, return to RUN and tick to the ring.
    task automatic ring_at_0002();
        do_reset(1'b1);
        presses(4, 1'b1, 1'b0);
        presses(2, 1'b0, 1'b1);
        presses(1, 1'b1, 1'b0);
        ticks(120);
    endtask

    initial begin
        // 1: reset values and carries.
        do_reset(1'b0);
        #1;
        check("rst_disp", 32'(disp_bcd), 32'h0000);
        check("rst_sec", 32'(sec_bcd), 32'h00);
        check("rst_mode", 32'(mode), 32'd0);
        check("rst_ring", 32'(ringing), 32'd0);
        check("rst_blink", 32'(blink), 32'd0);
        ticks(60);
        check("t60_disp", 32'(disp_bcd), 32'h0001);
        check("t60_sec", 32'(sec_bcd), 32'h00);
        ticks(3600);
        check("t3660_disp", 32'(disp_bcd), 32'h0101);

        // 2: setting time with wraps, blink, and alarm display in SET_A*.
        do_reset(1'b0);
        ticks(7);
        presses(1, 1'b1, 1'b0);
        check("set_th_mode", 32'(mode), 32'd1);
        check("set_th_sec_clr", 32'(sec_bcd), 32'h00);
        presses(25, 1'b0, 1'b1);
        check("hour_wrap", 32'(disp_bcd), 32'h0100);
        presses(1, 1'b1, 1'b0);
        presses(61, 1'b0, 1'b1);
        check("min_wrap", 32'(disp_bcd), 32'h0101);
        ticks(1);
        check("set_tm_sec_hold", 32'(sec_bcd), 32'h00);
        check("blink_toggle", 32'(blink), 32'd1);
        presses(1, 1'b1, 1'b0);
        check("set_ah_mode", 32'(mode), 32'd3);
        check("set_ah_disp_alarm", 32'(disp_bcd), 32'h0000);
        presses(2, 1'b1, 1'b0);
        check("back_run_mode", 32'(mode), 32'd0);
        check("back_run_sec", 32'(sec_bcd), 32'h00);
        check("back_run_blink", 32'(blink), 32'd0);
        check("back_run_disp", 32'(disp_bcd), 32'h0101);

        // 3: 23:59:59 -> 00:00:00.
        do_reset(1'b0);
        presses(1, 1'b1, 1'b0);
        presses(23, 1'b0, 1'b1);
        presses(1, 1'b1, 1'b0);
        presses(59, 1'b0, 1'b1);
        presses(3, 1'b1, 1'b0);
        ticks(59);
        check("pre_midnight_disp", 32'(disp_bcd), 32'h2359);
        check("pre_midnight_sec", 32'(sec_bcd), 32'h59);
        ticks(1);
        check("midnight_disp", 32'(disp_bcd), 32'h0000);
        check("midnight_sec", 32'(sec_bcd), 32'h00);

        // 4: alarm fires at 00:02:00 and auto-silences after 60 ticks.
        do_reset(1'b1);
        presses(4, 1'b1, 1'b0);
        presses(2, 1'b0, 1'b1);
        check("alarm_disp", 32'(disp_bcd), 32'h0002);
        presses(1, 1'b1, 1'b0);
        ticks(119);
        check("pre_ring", 32'(ringing), 32'd0);
        ticks(1);
        check("ring_on", 32'(ringing), 32'd1);
        check("ring_time", 32'(disp_bcd), 32'h0002);
        ticks(59);
        check("ring_59", 32'(ringing), 32'd1);
        ticks(1);
        check("ring_auto_off", 32'(ringing), 32'd0);

        // 5: snooze re-rings at 00:07:00, btn_mode dismisses without changing mode.
        ring_at_0002();
        check("snz_ring_on", 32'(ringing), 32'd1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        check("snz_off", 32'(ringing), 32'd0);
        ticks(299);
        check("snz_pre", 32'(ringing), 32'd0);
        ticks(1);
        check("snz_rering", 32'(ringing), 32'd1);
        check("snz_rering_time", 32'(disp_bcd), 32'h0007);
        presses(1, 1'b1, 1'b0);
        check("dismiss_off", 32'(ringing), 32'd0);
        check("dismiss_mode", 32'(mode), 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        check("snz_idle_ignored", 32'(ringing), 32'd0);

        // 6: mode+inc together, alarm_en drop, reset while ringing.
        do_reset(1'b0);
        presses(1, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        check("mode_inc_mode", 32'(mode), 32'd2);
        check("mode_inc_hour", 32'(disp_bcd), 32'h0000);
        ring_at_0002();
        @(negedge clk);
        alarm_en = 1'b0;
        @(posedge clk);
        #1;
        check("en_drop", 32'(ringing), 32'd0);
        ring_at_0002();
        check("pre_reset_ring", 32'(ringing), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("async_rst_ring", 32'(ringing), 32'd0);
        check("async_rst_disp", 32'(disp_bcd), 32'h0000);
        check("async_rst_mode", 32'(mode), 32'd0);
        check("async_rst_sec", 32'(sec_bcd), 32'h00);
        @(negedge clk);
        reset = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
